mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_pkg.sv | 25 ++
 rtl/mem_wb_pipe_reg.sv | 48 ++++
 rtl/mem_stage_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and field positions for the MEM stage controller and its MEM/WB register.
package mem_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // EX_MEM_MEM_signals = {MemWriteData[15:0], MemEnable, MemWrite}
    localparam int MEM_WRITE_BIT  = 0;
    localparam int MEM_ENABLE_BIT = 1;
    localparam int MEM_WDATA_LSB  = 2;
    localparam int MEM_WDATA_MSB  = 17;

    // WB_signals = {reg_rd[3:0], RegWrite, MemtoReg, HLT, PCS}
    localparam int WB_PCS_BIT      = 0;
    localparam int WB_HLT_BIT      = 1;
    localparam int WB_MEMTOREG_BIT = 2;
    localparam int WB_REGWRITE_BIT = 3;
    localparam int WB_RD_LSB       = 4;
    localparam int WB_RD_MSB       = 7;

    localparam logic [7:0] WB_BUBBLE = 8'h00;

endpackage

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: captures on wen, and on bubble clears only the write-back controls.
module mem_wb_pipe_reg
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wen,
    input  logic        bubble,
    input  logic [15:0] pc_next_i,
    input  logic [15:0] alu_out_i,
    input  logic [15:0] mem_data_i,
    input  logic [7:0]  wb_signals_i,
    output logic [15:0] pc_next_o,
    output logic [15:0] alu_out_o,
    output logic [15:0] mem_data_o,
    output logic [7:0]  wb_signals_o
);

    logic [15:0] pcNext_q;
    logic [15:0] aluOut_q;
    logic [15:0] memData_q;
    logic [7:0]  wbSignals_q;

    // A bubble keeps the data fields so only the control word marks the slot as empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcNext_q    <= '0;
            aluOut_q    <= '0;
            memData_q   <= '0;
            wbSignals_q <= '0;
        end else if (wen) begin
            if (bubble) begin
                wbSignals_q <= WB_BUBBLE;
            end else begin
                pcNext_q    <= pc_next_i;
                aluOut_q    <= alu_out_i;
                memData_q   <= mem_data_i;
                wbSignals_q <= wb_signals_i;
            end
        end
    end

    assign pc_next_o    = pcNext_q;
    assign alu_out_o    = aluOut_q;
    assign mem_data_o   = memData_q;
    assign wb_signals_o = wbSignals_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues data-memory accesses, stalls until ack, feeds MEM/WB.
// Optional watchdog abort is enabled with `define MEM_TIMEOUT_EN.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] EX_MEM_PC_next,
    input  logic [15:0] EX_MEM_ALU_out,
    input  logic [3:0]  EX_MEM_SrcReg2,
    input  logic [17:0] EX_MEM_MEM_signals,
    input  logic [7:0]  EX_MEM_WB_signals,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        mem_stall,
    output logic [15:0] MEM_WB_PC_next,
    output logic [15:0] MEM_WB_ALU_out,
    output logic [15:0] MEM_WB_MemData,
    output logic [7:0]  MEM_WB_WB_signals,
    output logic        mem_err
);

    state_e      state_q, state_d;
    logic [15:0] addr_q;
    logic        we_q;
    logic [15:0] wdata_q;

    logic        memEnable, memWrite, fwdHit;
    logic [15:0] storeData;
    logic        timeout, ackEff;
    logic [15:0] rdataEff, memDataIn;
    logic        reqC, weC;
    logic [15:0] addrC, wdataC;

    assign memEnable = EX_MEM_MEM_signals[MEM_ENABLE_BIT];
    assign memWrite  = EX_MEM_MEM_signals[MEM_WRITE_BIT];

    // Store data produced by a load still sitting in MEM/WB is forwarded around the register file.
    assign fwdHit = memWrite
                 && MEM_WB_WB_signals[WB_REGWRITE_BIT]
                 && MEM_WB_WB_signals[WB_MEMTOREG_BIT]
                 && (MEM_WB_WB_signals[WB_RD_MSB:WB_RD_LSB] == EX_MEM_SrcReg2)
                 && (EX_MEM_SrcReg2 != 4'd0);
    assign storeData = fwdHit ? MEM_WB_MemData : EX_MEM_MEM_signals[MEM_WDATA_MSB:MEM_WDATA_LSB];

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    assign timeout = (state_q == ST_WAIT) && (cnt_q == 8'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | timeout;
        if (state_q == ST_IDLE) begin
            cnt_d = 8'd0;
        end else if (!timeout) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;
`else
    assign timeout = 1'b0;
    // The comparison is constant-false; it only keeps the watchdog parameter referenced.
    assign mem_err = (TIMEOUT_CYCLES < 0);
`endif

    assign ackEff   = dmem_ack | timeout;
    assign rdataEff = timeout ? 16'h0000 : dmem_rdata;

    // The MEM/WB bubble in WAIT would break the forwarding match, so WAIT replays the values latched at issue.
    always_comb begin
        state_d = state_q;
        reqC    = 1'b0;
        addrC   = EX_MEM_ALU_out;
        weC     = memWrite;
        wdataC  = storeData;
        case (state_q)
            ST_IDLE: begin
                if (memEnable) begin
                    reqC = 1'b1;
                    if (!ackEff) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                reqC   = 1'b1;
                addrC  = addr_q;
                weC    = we_q;
                wdataC = wdata_q;
                if (ackEff) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!rst) begin
            reqC   = 1'b0;
            addrC  = 16'h0000;
            weC    = 1'b0;
            wdataC = 16'h0000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= 16'h0000;
            we_q    <= 1'b0;
            wdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE) begin
                addr_q  <= addrC;
                we_q    <= weC;
                wdata_q <= wdataC;
            end
        end
    end

    assign dmem_req   = reqC;
    assign dmem_we    = reqC & weC;
    assign dmem_addr  = addrC;
    assign dmem_wdata = wdataC;
    assign mem_stall  = reqC & ~ackEff;

    assign memDataIn = (memEnable && !memWrite) ? rdataEff : 16'h0000;

    mem_wb_pipe_reg u_mem_wb (
        .clk          (clk),
        .rst          (rst),
        .wen          (1'b1),
        .bubble       (mem_stall),
        .pc_next_i    (EX_MEM_PC_next),
        .alu_out_i    (EX_MEM_ALU_out),
        .mem_data_i   (memDataIn),
        .wb_signals_i (EX_MEM_WB_signals),
        .pc_next_o    (MEM_WB_PC_next),
        .alu_out_o    (MEM_WB_ALU_out),
        .mem_data_o   (MEM_WB_MemData),
        .wb_signals_o (MEM_WB_WB_signals)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] exPc, exAlu;
    logic [3:0]  exSrc2;
    logic [17:0] exMem;
    logic [7:0]  exWb;
    logic        dmemReq, dmemWe, dmemAck, memStall, memErr;
    logic [15:0] dmemAddr, dmemWdata, dmemRdata;
    logic [15:0] wbPc, wbAlu, wbData;
    logic [7:0]  wbSig;

    int testsRun    = 0;
    int testsFailed = 0;

    // Model of the MEM/WB slot as seen by the write-back stage.
    logic [15:0] mPc, mAlu, mData;
    logic [7:0]  mWb;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .EX_MEM_PC_next     (exPc),
        .EX_MEM_ALU_out     (exAlu),
        .EX_MEM_SrcReg2     (exSrc2),
        .EX_MEM_MEM_signals (exMem),
        .EX_MEM_WB_signals  (exWb),
        .dmem_req           (dmemReq),
        .dmem_we            (dmemWe),
        .dmem_addr          (dmemAddr),
        .dmem_wdata         (dmemWdata),
        .dmem_ack           (dmemAck),
        .dmem_rdata         (dmemRdata),
        .mem_stall          (memStall),
        .MEM_WB_PC_next     (wbPc),
        .MEM_WB_ALU_out     (wbAlu),
        .MEM_WB_MemData     (wbData),
        .MEM_WB_WB_signals  (wbSig),
        .mem_err            (memErr)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic we, input logic [15:0] addr,
                                 input logic [15:0] data, input logic [15:0] pc,
                                 input logic [3:0] src, input logic [7:0] wb);
        exPc   = pc;
        exAlu  = addr;
        exSrc2 = src;
        exMem  = {data, en, we};
        exWb   = wb;
    endtask

    task automatic checkMemWb(input string tag);
        checkOutput({tag, ".pc"},   wbPc,   mPc);
        checkOutput({tag, ".alu"},  wbAlu,  mAlu);
        checkOutput({tag, ".data"}, wbData, mData);
        checkOutput({tag, ".wb"},   16'(wbSig), 16'(mWb));
    endtask

    // One instruction through MEM: called at posedge+1, returns at posedge+1 after it has left the stage.
    task automatic doInstr(input string tag, input logic en, input logic we, input logic [15:0] addr,
                           input logic [15:0] data, input logic [15:0] pc, input logic [3:0] src,
                           input logic [7:0] wb, input int lat, input logic [15:0] rdata);
        logic [15:0] expWdata;
        logic        fwd;
        int          waits;
        fwd = we && mWb[3] && mWb[2] && (mWb[7:4] == src) && (src != 4'd0);
        expWdata = fwd ? mData : data;
        waits = en ? lat : 0;
        applyStimulus(en, we, addr, data, pc, src, wb);
        for (int c = 0; c <= waits; c++) begin
            if (en) dmemAck = (c == lat);
            else    dmemAck = 1'($urandom_range(0, 1));
            dmemRdata = (c == lat) ? rdata : 16'($urandom);
            #4;
            checkOutput({tag, ".req"},   16'(dmemReq),  16'(en));
            checkOutput({tag, ".stall"}, 16'(memStall), 16'(en && (c < lat)));
            checkOutput({tag, ".we"},    16'(dmemWe),   16'(en && we));
            if (en) begin
                checkOutput({tag, ".addr"}, dmemAddr, addr);
                if (we) checkOutput({tag, ".wdata"}, dmemWdata, expWdata);
            end
            @(posedge clk);
            #1;
            if (en && (c < lat)) begin
                mWb = 8'h00;
            end else begin
                mPc   = pc;
                mAlu  = addr;
                mData = (en && !we) ? rdata : 16'h0000;
                mWb   = wb;
            end
            checkMemWb(tag);
        end
        dmemAck = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        dmemAck = 1'b0;
        dmemRdata = 16'h0000;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 8'h00);
        mPc = '0; mAlu = '0; mData = '0; mWb = '0;

        // Reset state
        #12;
        checkMemWb("reset");
        checkOutput("reset.req", 16'(dmemReq), 16'd0);
        checkOutput("reset.err", 16'(memErr), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // ALU instruction passes straight through
        doInstr("alu", 1'b0, 1'b0, 16'h1111, 16'h0000, 16'h0002, 4'd0, 8'h38, 0, 16'h0000);
        // Zero-wait load into R5
        doInstr("load0", 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0004, 4'd0, 8'h5C, 0, 16'hBEEF);
        // Store forwarding the just-loaded R5, waited so the latched data must survive the bubble
        doInstr("fwdStore", 1'b1, 1'b1, 16'h0020, 16'h7777, 16'h0006, 4'd5, 8'h00, 2, 16'h0000);
        doInstr("load1", 1'b1, 1'b0, 16'h0042, 16'h0000, 16'h0008, 4'd0, 8'h5C, 1, 16'hCAFE);
        doInstr("noFwdR0", 1'b1, 1'b1, 16'h0022, 16'h5555, 16'h000A, 4'd0, 8'h00, 0, 16'h0000);
        // Store with a three-cycle memory wait
        doInstr("store3", 1'b1, 1'b1, 16'h0010, 16'h1234, 16'h000C, 4'd3, 8'h00, 3, 16'h0000);

        // Reset in the second WAIT cycle abandons the access
        applyStimulus(1'b1, 1'b0, 16'h0080, 16'h0000, 16'h000E, 4'd0, 8'h6C);
        dmemAck = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rstWait.stall", 16'(memStall), 16'd1);
        rst = 1'b0;
        #1;
        mPc = '0; mAlu = '0; mData = '0; mWb = '0;
        checkOutput("rstWait.req", 16'(dmemReq), 16'd0);
        checkOutput("rstWait.stallLow", 16'(memStall), 16'd0);
        checkMemWb("rstWait");
        dmemAck = 1'b1;
        dmemRdata = 16'hDEAD;
        @(posedge clk); #1;
        checkMemWb("lateAck");
        dmemAck = 1'b0;
        rst = 1'b1;
        doInstr("postRst", 1'b0, 1'b0, 16'h2222, 16'h0000, 16'h0010, 4'd0, 8'h38, 0, 16'h0000);

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            logic en, we;
            en = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            doInstr("rand", en, we, 16'($urandom), 16'($urandom), 16'($urandom),
                    4'($urandom_range(0, 3)),
                    {2'b00, 2'($urandom_range(0, 3)), 4'($urandom)},
                    int'($urandom_range(0, 3)), 16'($urandom));
        end

`ifdef MEM_TIMEOUT_EN
        // Watchdog: issue cycle plus four WAIT cycles stall, then an aborted completion
        applyStimulus(1'b1, 1'b0, 16'h0090, 16'h0000, 16'h0020, 4'd0, 8'h7C);
        dmemAck = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #4;
            checkOutput("tmo.stall", 16'(memStall), 16'd1);
            @(posedge clk); #1;
        end
        #4;
        checkOutput("tmo.release", 16'(memStall), 16'd0);
        @(posedge clk); #1;
        mPc = 16'h0020; mAlu = 16'h0090; mData = 16'h0000; mWb = 8'h7C;
        checkMemWb("tmo");
        checkOutput("tmo.err", 16'(memErr), 16'd1);
        doInstr("tmoAfter", 1'b0, 1'b0, 16'h3333, 16'h0000, 16'h0022, 4'd0, 8'h38, 0, 16'h0000);
        checkOutput("tmo.errSticky", 16'(memErr), 16'd1);
`else
        checkOutput("noWatchdog.err", 16'(memErr), 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
